// File: rtl/otp_part_buf_loader.sv
// Loads one OTP partition word by word into a local buffer and checks the XOR digest
// held in the last word before exposing the data to the partition consumer.
module otp_part_buf_loader #(
  parameter int unsigned NumWords = 4,
  parameter int unsigned WordW    = 32,
  parameter int unsigned AddrW    = 11,
  parameter int unsigned BaseAddr = 0,
  parameter logic [NumWords*WordW-1:0] InvDefault = (NumWords*WordW)'(1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      init_req_i,
  output logic                      init_done_o,
  output logic                      otp_req_o,
  output logic [AddrW-1:0]          otp_addr_o,
  input  logic                      otp_gnt_i,
  input  logic                      otp_rvalid_i,
  input  logic [WordW-1:0]          otp_rdata_i,
  input  logic                      otp_err_i,
  output logic [NumWords*WordW-1:0] part_buf_o,
  output logic                      part_valid_o,
  output logic                      part_err_o
);

  localparam int unsigned CntW = $clog2(NumWords);
  localparam int unsigned BufW = NumWords * WordW;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumWords - 1);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StError} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WordW-1:0]  acc_q, acc_d;
  logic [BufW-1:0]   part_q, part_d;
  logic              done_q, done_d;
  logic              term_q, term_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      part_q  <= InvDefault;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      part_q  <= part_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    part_d  = part_q;
    unique case (state_q)
      StIdle: begin
        if (init_req_i) begin
          cnt_d   = '0;
          acc_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        // A response with no read outstanding means the arbiter lost track.
        if (otp_rvalid_i) begin
          state_d = StError;
        end else if (otp_gnt_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (otp_rvalid_i) begin
          if (otp_err_i) begin
            state_d = StError;
          end else begin
            part_d[cnt_q*WordW +: WordW] = otp_rdata_i;
            if (cnt_q == LastCnt) begin
              state_d = (otp_rdata_i == acc_q) ? StDone : StError;
            end else begin
              acc_d   = acc_q ^ otp_rdata_i;
              cnt_d   = cnt_q + CntW'(1);
              state_d = StReq;
            end
          end
        end
      end
      StDone, StError: ;
      default: state_d = StIdle;
    endcase
  end

  // Pulse only on the transition into a terminal state.
  always_comb begin
    term_q = (state_q == StDone) || (state_q == StError);
    term_d = (state_d == StDone) || (state_d == StError);
    done_d = term_d && !term_q;
  end

  always_comb begin
    init_done_o  = done_q;
    otp_req_o    = (state_q == StReq);
    otp_addr_o   = AddrW'(BaseAddr) + AddrW'(cnt_q);
    part_valid_o = (state_q == StDone);
    part_err_o   = (state_q == StError);
    part_buf_o   = (state_q == StDone) ? part_q : InvDefault;
  end

endmodule

// File: tb/tb_otp_part_buf_loader.sv
// Directed bench for otp_part_buf_loader; expected read addresses go through a scoreboard queue.
module tb_otp_part_buf_loader;

  localparam int NW = 4;
  localparam int WW = 32;
  localparam int AW = 11;
  localparam int unsigned Base = 16;
  localparam logic [127:0] InvDef = 128'h1;
  localparam logic [127:0] GoodBuf = {32'h77777777, 32'h44444444, 32'h22222222, 32'h11111111};

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          init_req_i;
  logic          init_done_o;
  logic          otp_req_o;
  logic [AW-1:0] otp_addr_o;
  logic          otp_gnt_i;
  logic          otp_rvalid_i;
  logic [WW-1:0] otp_rdata_i;
  logic          otp_err_i;
  logic [127:0]  part_buf_o;
  logic          part_valid_o;
  logic          part_err_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   words[4];
  int            dc;

  always #5 clk_i = ~clk_i;

  otp_part_buf_loader #(
    .NumWords  (NW),
    .WordW     (WW),
    .AddrW     (AW),
    .BaseAddr  (Base),
    .InvDefault(InvDef)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .init_req_i  (init_req_i),
    .init_done_o (init_done_o),
    .otp_req_o   (otp_req_o),
    .otp_addr_o  (otp_addr_o),
    .otp_gnt_i   (otp_gnt_i),
    .otp_rvalid_i(otp_rvalid_i),
    .otp_rdata_i (otp_rdata_i),
    .otp_err_i   (otp_err_i),
    .part_buf_o  (part_buf_o),
    .part_valid_o(part_valid_o),
    .part_err_o  (part_err_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni       = 1'b0;
    init_req_i   = 1'b0;
    otp_gnt_i    = 1'b0;
    otp_rvalid_i = 1'b0;
    otp_err_i    = 1'b0;
    otp_rdata_i  = '0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  // Drives one full load; returns the number of edges from init_req to the done pulse.
  task automatic run_load(input int stall_word, input int stall_n, input int err_word,
                          output int done_cyc);
    int cyc;
    logic [AW-1:0] a;
    cyc = 0;
    for (int i = 0; i < NW; i++) begin
      if (err_word < 0 || i <= err_word) exp_addr_q.push_back(AW'(Base + i));
    end
    init_req_i = 1'b1;
    tick();
    cyc++;
    init_req_i = 1'b0;
    for (int k = 0; k < NW; k++) begin
      if (k == stall_word) begin
        for (int s = 0; s < stall_n; s++) begin
          chk("stall_req", otp_req_o, 1);
          chk("stall_addr", otp_addr_o, AW'(Base + k));
          tick();
          cyc++;
        end
      end
      chk("req_hi", otp_req_o, 1);
      if (exp_addr_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL sb_underflow: observed addr %0h expected none", otp_addr_o);
      end else begin
        a = exp_addr_q.pop_front();
        chk("addr", otp_addr_o, a);
      end
      otp_gnt_i = 1'b1;
      tick();
      cyc++;
      otp_gnt_i = 1'b0;
      chk("req_lo_wait", otp_req_o, 0);
      otp_rvalid_i = 1'b1;
      otp_rdata_i  = words[k];
      otp_err_i    = (k == err_word);
      tick();
      cyc++;
      otp_rvalid_i = 1'b0;
      otp_err_i    = 1'b0;
      otp_rdata_i  = '0;
      if (k == err_word) break;
      if (k < NW - 1) chk("no_done_mid", init_done_o, 0);
    end
    done_cyc = cyc;
    chk("done_pulse", init_done_o, 1);
    chk("sb_drained", exp_addr_q.size(), 0);
    tick();
    chk("done_once", init_done_o, 0);
    for (int j = 0; j < 3; j++) begin
      chk("no_req_after", otp_req_o, 0);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    words[0] = 32'h11111111;
    words[1] = 32'h22222222;
    words[2] = 32'h44444444;
    words[3] = 32'h77777777;

    do_reset();
    chk("rst_req", otp_req_o, 0);
    chk("rst_addr", otp_addr_o, AW'(Base));
    chk("rst_done", init_done_o, 0);
    chk("rst_valid", part_valid_o, 0);
    chk("rst_err", part_err_o, 0);
    chk("rst_buf", part_buf_o, InvDef);

    // Good load, zero wait
    run_load(-1, 0, -1, dc);
    chk("good_latency", dc, 9);
    chk("good_valid", part_valid_o, 1);
    chk("good_err", part_err_o, 0);
    chk("good_buf", part_buf_o, GoodBuf);

    // Re-request in DONE is ignored
    init_req_i = 1'b1;
    tick();
    init_req_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("rereq_no_req", otp_req_o, 0);
      chk("rereq_valid", part_valid_o, 1);
      chk("rereq_no_done", init_done_o, 0);
      tick();
    end

    // Digest mismatch
    do_reset();
    words[3] = 32'h77777776;
    run_load(-1, 0, -1, dc);
    chk("dig_latency", dc, 9);
    chk("dig_err", part_err_o, 1);
    chk("dig_valid", part_valid_o, 0);
    chk("dig_buf", part_buf_o, InvDef);
    words[3] = 32'h77777777;

    // Uncorrectable error on word 1
    do_reset();
    run_load(-1, 0, 1, dc);
    chk("ecc_latency", dc, 5);
    chk("ecc_err", part_err_o, 1);
    chk("ecc_valid", part_valid_o, 0);
    chk("ecc_buf", part_buf_o, InvDef);

    // Grant stall of 5 cycles on word 2
    do_reset();
    run_load(2, 5, -1, dc);
    chk("stall_latency", dc, 14);
    chk("stall_valid", part_valid_o, 1);
    chk("stall_buf", part_buf_o, GoodBuf);

    // Reset while waiting on word 2
    do_reset();
    init_req_i = 1'b1;
    tick();
    init_req_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      otp_gnt_i = 1'b1;
      tick();
      otp_gnt_i    = 1'b0;
      otp_rvalid_i = 1'b1;
      otp_rdata_i  = words[k];
      tick();
      otp_rvalid_i = 1'b0;
    end
    otp_gnt_i = 1'b1;
    tick();
    otp_gnt_i = 1'b0;
    chk("mid_wait_req", otp_req_o, 0);
    chk("mid_wait_addr", otp_addr_o, AW'(Base + 2));
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_req", otp_req_o, 0);
    chk("arst_addr", otp_addr_o, AW'(Base));
    chk("arst_done", init_done_o, 0);
    chk("arst_valid", part_valid_o, 0);
    chk("arst_err", part_err_o, 0);
    chk("arst_buf", part_buf_o, InvDef);
    tick();
    rst_ni = 1'b1;
    tick();
    otp_rvalid_i = 1'b1;
    otp_rdata_i  = words[2];
    tick();
    otp_rvalid_i = 1'b0;
    otp_rdata_i  = '0;
    chk("stale_req", otp_req_o, 0);
    chk("stale_err", part_err_o, 0);
    chk("stale_valid", part_valid_o, 0);
    chk("stale_buf", part_buf_o, InvDef);
    run_load(-1, 0, -1, dc);
    chk("reload_latency", dc, 9);
    chk("reload_valid", part_valid_o, 1);
    chk("reload_buf", part_buf_o, GoodBuf);

    // rvalid while in REQ
    do_reset();
    init_req_i = 1'b1;
    tick();
    init_req_i = 1'b0;
    chk("proto_req", otp_req_o, 1);
    otp_rvalid_i = 1'b1;
    otp_rdata_i  = words[0];
    tick();
    otp_rvalid_i = 1'b0;
    otp_rdata_i  = '0;
    chk("proto_err", part_err_o, 1);
    chk("proto_done", init_done_o, 1);
    chk("proto_valid", part_valid_o, 0);
    chk("proto_buf", part_buf_o, InvDef);
    tick();
    chk("proto_no_req", otp_req_o, 0);
    chk("proto_done_once", init_done_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
